// File: rtl/framing_pkg.sv
// framing_pkg
//   Shared types and helpers for the framing_tid framer/deframer pair.
//   rx_state_t / tx_state_t : FSM state encodings for the deframer and framer
//   DROP_CNT_W              : width of the saturating RX drop counter
//   is_special()            : true when a byte collides with a control marker
//                             and therefore has to be escaped on the wire
package framing_pkg;

    localparam int DROP_CNT_W = 16;

    typedef enum logic [2:0] {
        RX_IDLE     = 3'd0,
        RX_ID       = 3'd1,
        RX_ID_ESC   = 3'd2,
        RX_DATA     = 3'd3,
        RX_DATA_ESC = 3'd4
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE     = 3'd0,
        TX_START    = 3'd1,
        TX_ID       = 3'd2,
        TX_ID_ESC   = 3'd3,
        TX_DATA     = 3'd4,
        TX_DATA_ESC = 3'd5,
        TX_STOP     = 3'd6
    } tx_state_t;

    function automatic logic is_special(input logic [7:0] b,
                                        input logic [7:0] esc,
                                        input logic [7:0] start,
                                        input logic [7:0] stop);
        return (b == esc) || (b == start) || (b == stop);
    endfunction

endpackage

// File: rtl/framing_tid_rx.sv
// framing_tid_rx
//   Deframer: turns the escaped wire byte stream back into AXI4-Stream
//   payload frames tagged with the channel id carried after START.
//   aclk / areset          : clock, synchronous active-high reset
//   rx_byte_*              : incoming wire bytes (AXIS slave)
//   rx_frame_*             : decoded payload beats (AXIS master), tid = channel,
//                            tuser = frame aborted or truncated (on tlast beat)
//   rx_drop_cnt            : saturating count of aborted/truncated frames
module framing_tid_rx
    import framing_pkg::*;
#(
    parameter logic [7:0] ESCAPE_BYTE = 8'h7F,
    parameter logic [7:0] START_BYTE  = 8'h7D,
    parameter logic [7:0] STOP_BYTE   = 8'h7E,
    parameter int         TID_WIDTH   = 2,
    parameter int         MAX_LEN     = 1024
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  rx_byte_tvalid,
    output logic                  rx_byte_tready,
    input  logic [7:0]            rx_byte_tdata,
    output logic                  rx_frame_tvalid,
    input  logic                  rx_frame_tready,
    output logic [7:0]            rx_frame_tdata,
    output logic                  rx_frame_tlast,
    output logic [TID_WIDTH-1:0]  rx_frame_tid,
    output logic                  rx_frame_tuser,
    output logic [DROP_CNT_W-1:0] rx_drop_cnt
);

    // The length counter only needs to reach MAX_LEN; with MAX_LEN = 0 it is unused.
    localparam int                CNT_W   = (MAX_LEN > 0) ? $clog2(MAX_LEN + 1) : 1;
    localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_LEN);

    rx_state_t              state;
    rx_state_t              next_state;
    logic [7:0]             hold_data;
    logic                   hold_valid;
    logic [TID_WIDTH-1:0]   frame_tid;
    logic [CNT_W-1:0]       byte_cnt;

    logic                   accept;
    logic                   oversize;
    logic                   payload;
    logic                   push;
    logic                   push_last;
    logic                   push_user;
    logic                   take;
    logic                   drop;
    logic                   start_frame;
    logic                   end_frame;

    // Every wire byte, even one that produces no output, waits for room in
    // the output register so a push can never overwrite an unaccepted beat.
    assign rx_byte_tready = !rx_frame_tvalid || rx_frame_tready;
    assign accept         = rx_byte_tvalid && rx_byte_tready;
    assign oversize       = (MAX_LEN != 0) && (byte_cnt == MAX_CNT);

    // Decode the accepted byte against the current state. The hold register
    // delays each payload byte by one so the frame's final byte can be
    // tagged with tlast when STOP (or an abort) arrives.
    always_comb begin
        next_state  = state;
        payload     = 1'b0;
        push        = 1'b0;
        push_last   = 1'b0;
        push_user   = 1'b0;
        take        = 1'b0;
        drop        = 1'b0;
        start_frame = 1'b0;
        end_frame   = 1'b0;
        if (accept) begin
            case (state)
                RX_IDLE: begin
                    if (rx_byte_tdata == START_BYTE) next_state = RX_ID;
                end
                RX_ID: begin
                    if (rx_byte_tdata == ESCAPE_BYTE)     next_state = RX_ID_ESC;
                    else if (rx_byte_tdata == STOP_BYTE)  next_state = RX_IDLE;
                    else if (rx_byte_tdata == START_BYTE) next_state = RX_ID;
                    else begin
                        start_frame = 1'b1;
                        next_state  = RX_DATA;
                    end
                end
                RX_ID_ESC: begin
                    start_frame = 1'b1;
                    next_state  = RX_DATA;
                end
                RX_DATA: begin
                    if (rx_byte_tdata == ESCAPE_BYTE) begin
                        next_state = RX_DATA_ESC;
                    end else if (rx_byte_tdata == STOP_BYTE) begin
                        // An empty frame simply vanishes here without being counted.
                        push       = hold_valid;
                        push_last  = 1'b1;
                        end_frame  = 1'b1;
                        next_state = RX_IDLE;
                    end else if (rx_byte_tdata == START_BYTE) begin
                        push       = hold_valid;
                        push_last  = 1'b1;
                        push_user  = 1'b1;
                        drop       = 1'b1;
                        end_frame  = 1'b1;
                        next_state = RX_ID;
                    end else begin
                        payload = 1'b1;
                    end
                end
                RX_DATA_ESC: begin
                    // The escaped byte is always literal, including START.
                    payload = 1'b1;
                end
                default: next_state = RX_IDLE;
            endcase
            if (payload) begin
                push = hold_valid;
                if (oversize) begin
                    push_last  = 1'b1;
                    push_user  = 1'b1;
                    drop       = 1'b1;
                    end_frame  = 1'b1;
                    next_state = RX_IDLE;
                end else begin
                    take       = 1'b1;
                    next_state = RX_DATA;
                end
            end
        end
    end

    // State, hold register, output register and drop counter.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state           <= RX_IDLE;
            hold_data       <= '0;
            hold_valid      <= 1'b0;
            frame_tid       <= '0;
            byte_cnt        <= '0;
            rx_frame_tvalid <= 1'b0;
            rx_frame_tdata  <= '0;
            rx_frame_tlast  <= 1'b0;
            rx_frame_tuser  <= 1'b0;
            rx_frame_tid    <= '0;
            rx_drop_cnt     <= '0;
        end else begin
            state <= next_state;
            if (rx_frame_tvalid && rx_frame_tready) rx_frame_tvalid <= 1'b0;
            if (push) begin
                rx_frame_tvalid <= 1'b1;
                rx_frame_tdata  <= hold_data;
                rx_frame_tlast  <= push_last;
                rx_frame_tuser  <= push_user;
                rx_frame_tid    <= frame_tid;
            end
            if (start_frame) begin
                frame_tid  <= rx_byte_tdata[TID_WIDTH-1:0];
                hold_valid <= 1'b0;
                byte_cnt   <= '0;
            end
            if (take) begin
                hold_data  <= rx_byte_tdata;
                hold_valid <= 1'b1;
                if (MAX_LEN != 0) byte_cnt <= byte_cnt + 1'b1;
            end
            if (end_frame) hold_valid <= 1'b0;
            if (drop && (rx_drop_cnt != '1)) rx_drop_cnt <= rx_drop_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/framing_tid_tx.sv
// framing_tid_tx
//   Framer: wraps AXI4-Stream payload frames as START, ID, payload, STOP
//   on the wire, escaping any ID or payload byte that matches a marker.
//   aclk / areset : clock, synchronous active-high reset
//   tx_frame_*    : payload beats in (AXIS slave); tid sampled on first beat
//   tx_byte_*     : outgoing wire bytes (AXIS master)
module framing_tid_tx
    import framing_pkg::*;
#(
    parameter logic [7:0] ESCAPE_BYTE = 8'h7F,
    parameter logic [7:0] START_BYTE  = 8'h7D,
    parameter logic [7:0] STOP_BYTE   = 8'h7E,
    parameter int         TID_WIDTH   = 2
) (
    input  logic                 aclk,
    input  logic                 areset,
    output logic                 tx_byte_tvalid,
    input  logic                 tx_byte_tready,
    output logic [7:0]           tx_byte_tdata,
    input  logic                 tx_frame_tvalid,
    output logic                 tx_frame_tready,
    input  logic [7:0]           tx_frame_tdata,
    input  logic                 tx_frame_tlast,
    input  logic [TID_WIDTH-1:0] tx_frame_tid
);

    tx_state_t            state;
    tx_state_t            next_state;
    logic [TID_WIDTH-1:0] frame_tid;
    logic [7:0]           id_byte;
    logic                 id_special;
    logic                 data_special;

    assign id_byte      = 8'(frame_tid);
    assign id_special   = is_special(id_byte, ESCAPE_BYTE, START_BYTE, STOP_BYTE);
    assign data_special = is_special(tx_frame_tdata, ESCAPE_BYTE, START_BYTE, STOP_BYTE);

    // Wire byte selection and payload pop. Payload bytes are passed straight
    // through from the slave side, which keeps them stable until accepted
    // and allows one wire byte per cycle. A special payload byte is popped
    // only when its second (raw) wire byte goes out.
    always_comb begin
        next_state      = state;
        tx_byte_tvalid  = 1'b0;
        tx_byte_tdata   = '0;
        tx_frame_tready = 1'b0;
        case (state)
            TX_IDLE: begin
                if (tx_frame_tvalid) next_state = TX_START;
            end
            TX_START: begin
                tx_byte_tvalid = 1'b1;
                tx_byte_tdata  = START_BYTE;
                if (tx_byte_tready) next_state = TX_ID;
            end
            TX_ID: begin
                tx_byte_tvalid = 1'b1;
                tx_byte_tdata  = id_special ? ESCAPE_BYTE : id_byte;
                if (tx_byte_tready) next_state = id_special ? TX_ID_ESC : TX_DATA;
            end
            TX_ID_ESC: begin
                tx_byte_tvalid = 1'b1;
                tx_byte_tdata  = id_byte;
                if (tx_byte_tready) next_state = TX_DATA;
            end
            TX_DATA: begin
                tx_byte_tvalid = tx_frame_tvalid;
                if (data_special) begin
                    tx_byte_tdata = ESCAPE_BYTE;
                    if (tx_frame_tvalid && tx_byte_tready) next_state = TX_DATA_ESC;
                end else begin
                    tx_byte_tdata   = tx_frame_tdata;
                    tx_frame_tready = tx_byte_tready;
                    if (tx_frame_tvalid && tx_byte_tready)
                        next_state = tx_frame_tlast ? TX_STOP : TX_DATA;
                end
            end
            TX_DATA_ESC: begin
                tx_byte_tvalid  = tx_frame_tvalid;
                tx_byte_tdata   = tx_frame_tdata;
                tx_frame_tready = tx_byte_tready;
                if (tx_frame_tvalid && tx_byte_tready)
                    next_state = tx_frame_tlast ? TX_STOP : TX_DATA;
            end
            TX_STOP: begin
                tx_byte_tvalid = 1'b1;
                tx_byte_tdata  = STOP_BYTE;
                if (tx_byte_tready) next_state = TX_IDLE;
            end
            default: next_state = TX_IDLE;
        endcase
    end

    // State register; the channel id is captured from the first beat only.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state     <= TX_IDLE;
            frame_tid <= '0;
        end else begin
            state <= next_state;
            if ((state == TX_IDLE) && tx_frame_tvalid) frame_tid <= tx_frame_tid;
        end
    end

endmodule

// File: rtl/framing_tid.sv
// framing_tid
//   Byte-stream framer/deframer with channel id, between a UART-class byte
//   link and per-channel packet logic. RX and TX paths are independent.
//   aclk / areset : clock, synchronous active-high reset
//   rx_byte_*     : wire bytes in        rx_frame_* : decoded frames out
//   rx_drop_cnt   : aborted/truncated frame count (saturating)
//   tx_frame_*    : frames in            tx_byte_*  : wire bytes out
module framing_tid
    import framing_pkg::*;
#(
    parameter logic [7:0] ESCAPE_BYTE = 8'h7F,
    parameter logic [7:0] START_BYTE  = 8'h7D,
    parameter logic [7:0] STOP_BYTE   = 8'h7E,
    parameter int         TID_WIDTH   = 2,
    parameter int         MAX_LEN     = 1024
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  rx_byte_tvalid,
    output logic                  rx_byte_tready,
    input  logic [7:0]            rx_byte_tdata,
    output logic                  rx_frame_tvalid,
    input  logic                  rx_frame_tready,
    output logic [7:0]            rx_frame_tdata,
    output logic                  rx_frame_tlast,
    output logic [TID_WIDTH-1:0]  rx_frame_tid,
    output logic                  rx_frame_tuser,
    output logic [DROP_CNT_W-1:0] rx_drop_cnt,
    output logic                  tx_byte_tvalid,
    input  logic                  tx_byte_tready,
    output logic [7:0]            tx_byte_tdata,
    input  logic                  tx_frame_tvalid,
    output logic                  tx_frame_tready,
    input  logic [7:0]            tx_frame_tdata,
    input  logic                  tx_frame_tlast,
    input  logic [TID_WIDTH-1:0]  tx_frame_tid
);

    framing_tid_rx #(
        .ESCAPE_BYTE (ESCAPE_BYTE),
        .START_BYTE  (START_BYTE),
        .STOP_BYTE   (STOP_BYTE),
        .TID_WIDTH   (TID_WIDTH),
        .MAX_LEN     (MAX_LEN)
    ) u_rx (
        .aclk            (aclk),
        .areset          (areset),
        .rx_byte_tvalid  (rx_byte_tvalid),
        .rx_byte_tready  (rx_byte_tready),
        .rx_byte_tdata   (rx_byte_tdata),
        .rx_frame_tvalid (rx_frame_tvalid),
        .rx_frame_tready (rx_frame_tready),
        .rx_frame_tdata  (rx_frame_tdata),
        .rx_frame_tlast  (rx_frame_tlast),
        .rx_frame_tid    (rx_frame_tid),
        .rx_frame_tuser  (rx_frame_tuser),
        .rx_drop_cnt     (rx_drop_cnt)
    );

    framing_tid_tx #(
        .ESCAPE_BYTE (ESCAPE_BYTE),
        .START_BYTE  (START_BYTE),
        .STOP_BYTE   (STOP_BYTE),
        .TID_WIDTH   (TID_WIDTH)
    ) u_tx (
        .aclk            (aclk),
        .areset          (areset),
        .tx_byte_tvalid  (tx_byte_tvalid),
        .tx_byte_tready  (tx_byte_tready),
        .tx_byte_tdata   (tx_byte_tdata),
        .tx_frame_tvalid (tx_frame_tvalid),
        .tx_frame_tready (tx_frame_tready),
        .tx_frame_tdata  (tx_frame_tdata),
        .tx_frame_tlast  (tx_frame_tlast),
        .tx_frame_tid    (tx_frame_tid)
    );

endmodule

// File: tb/tb_framing_tid.sv
// tb_framing_tid
//   Scoreboard bench for framing_tid. Expected RX beats and TX wire bytes are
//   queued when stimulus is issued; monitor processes pop and compare on every
//   output transfer. A second instance with MAX_LEN=4 covers truncation.
module tb_framing_tid;

    typedef logic [7:0] byte_q_t[$];

    logic aclk = 1'b0;
    logic areset;
    always #5 aclk = ~aclk;

    // main instance
    logic        rx_byte_tvalid, rx_byte_tready;
    logic [7:0]  rx_byte_tdata;
    logic        rx_frame_tvalid, rx_frame_tready;
    logic [7:0]  rx_frame_tdata;
    logic        rx_frame_tlast, rx_frame_tuser;
    logic [1:0]  rx_frame_tid;
    logic [15:0] rx_drop_cnt;
    logic        tx_byte_tvalid, tx_byte_tready;
    logic [7:0]  tx_byte_tdata;
    logic        tx_frame_tvalid, tx_frame_tready;
    logic [7:0]  tx_frame_tdata;
    logic        tx_frame_tlast;
    logic [1:0]  tx_frame_tid;

    // small (MAX_LEN=4) instance, RX only
    logic        s_rx_valid, s_rx_ready;
    logic        s_out_valid;
    logic        s_out_ready = 1'b1;
    logic [7:0]  s_out_data;
    logic        s_out_last, s_out_user;
    logic [1:0]  s_out_tid;
    logic [15:0] s_drop_cnt;
    logic        s_tx_valid;
    logic [7:0]  s_tx_data;
    logic        s_tx_frame_ready;

    // stimulus control
    logic       drv_valid = 1'b0;
    logic [7:0] drv_data = 8'h00;
    logic       drv_ready;
    logic       sel_small = 1'b0;
    logic       loop_mode = 1'b0;
    logic       tx_rdy_drv = 1'b0;
    logic       link_gate;
    logic       rand_ready = 1'b0;

    assign rx_byte_tvalid = loop_mode ? (tx_byte_tvalid && link_gate) : (drv_valid && !sel_small);
    assign rx_byte_tdata  = loop_mode ? tx_byte_tdata : drv_data;
    assign tx_byte_tready = loop_mode ? (rx_byte_tready && link_gate) : tx_rdy_drv;
    assign s_rx_valid     = drv_valid && sel_small;
    assign drv_ready      = sel_small ? s_rx_ready : rx_byte_tready;

    framing_tid dut (
        .aclk(aclk), .areset(areset),
        .rx_byte_tvalid(rx_byte_tvalid), .rx_byte_tready(rx_byte_tready), .rx_byte_tdata(rx_byte_tdata),
        .rx_frame_tvalid(rx_frame_tvalid), .rx_frame_tready(rx_frame_tready), .rx_frame_tdata(rx_frame_tdata),
        .rx_frame_tlast(rx_frame_tlast), .rx_frame_tid(rx_frame_tid), .rx_frame_tuser(rx_frame_tuser),
        .rx_drop_cnt(rx_drop_cnt),
        .tx_byte_tvalid(tx_byte_tvalid), .tx_byte_tready(tx_byte_tready), .tx_byte_tdata(tx_byte_tdata),
        .tx_frame_tvalid(tx_frame_tvalid), .tx_frame_tready(tx_frame_tready), .tx_frame_tdata(tx_frame_tdata),
        .tx_frame_tlast(tx_frame_tlast), .tx_frame_tid(tx_frame_tid)
    );

    framing_tid #(.MAX_LEN(4)) dut_small (
        .aclk(aclk), .areset(areset),
        .rx_byte_tvalid(s_rx_valid), .rx_byte_tready(s_rx_ready), .rx_byte_tdata(drv_data),
        .rx_frame_tvalid(s_out_valid), .rx_frame_tready(s_out_ready), .rx_frame_tdata(s_out_data),
        .rx_frame_tlast(s_out_last), .rx_frame_tid(s_out_tid), .rx_frame_tuser(s_out_user),
        .rx_drop_cnt(s_drop_cnt),
        .tx_byte_tvalid(s_tx_valid), .tx_byte_tready(1'b0), .tx_byte_tdata(s_tx_data),
        .tx_frame_tvalid(1'b0), .tx_frame_tready(s_tx_frame_ready), .tx_frame_tdata(8'h00),
        .tx_frame_tlast(1'b0), .tx_frame_tid(2'b00)
    );

    // scoreboard: RX beats packed as {data, last, user, tid}
    logic [11:0] rx_exp[$];
    logic [11:0] s_exp[$];
    logic [7:0]  tx_exp[$];
    int total = 0;
    int bad = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic reportUnexpected(input string name, input logic [31:0] actual);
        total++;
        bad++;
        $display("[TB] FAIL %s: got 0x%0h, expected no transfer at %0t", name, actual, $time);
    endtask

    // monitors sample at the negedge, half a cycle away from the active edge
    always @(negedge aclk) begin
        if (!areset && rx_frame_tvalid && rx_frame_tready) begin
            if (rx_exp.size() == 0) reportUnexpected("rx_beat", {20'd0, rx_frame_tdata, rx_frame_tlast, rx_frame_tuser, rx_frame_tid});
            else checkOutput("rx_beat", {20'd0, rx_frame_tdata, rx_frame_tlast, rx_frame_tuser, rx_frame_tid},
                             {20'd0, rx_exp.pop_front()});
        end
        if (!areset && tx_byte_tvalid && tx_byte_tready) begin
            if (tx_exp.size() == 0) reportUnexpected("tx_wire", {24'd0, tx_byte_tdata});
            else checkOutput("tx_wire", {24'd0, tx_byte_tdata}, {24'd0, tx_exp.pop_front()});
        end
        if (!areset && s_out_valid && s_out_ready) begin
            if (s_exp.size() == 0) reportUnexpected("small_rx_beat", {20'd0, s_out_data, s_out_last, s_out_user, s_out_tid});
            else checkOutput("small_rx_beat", {20'd0, s_out_data, s_out_last, s_out_user, s_out_tid},
                             {20'd0, s_exp.pop_front()});
        end
    end

    // random backpressure on the frame output and the loopback link
    initial begin
        rx_frame_tready = 1'b1;
        link_gate = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            rx_frame_tready = rand_ready ? ($urandom_range(0, 99) >= 30) : 1'b1;
            link_gate       = rand_ready ? ($urandom_range(0, 99) < 60) : 1'b1;
        end
    end

    // reference model: wire encoding of one byte
    task automatic pushEncoded(input logic [7:0] b);
        if (b == 8'h7D || b == 8'h7E || b == 8'h7F) tx_exp.push_back(8'h7F);
        tx_exp.push_back(b);
    endtask

    // drive raw wire bytes into the selected RX path
    task automatic applyStimulus(input byte_q_t bytes);
        foreach (bytes[i]) begin
            drv_valid = 1'b1;
            drv_data  = bytes[i];
            for (int c = 0; ; c++) begin
                @(negedge aclk);
                if (drv_ready) break;
                if (c > 500) begin
                    reportUnexpected("rx_byte_ready_timeout", {24'd0, bytes[i]});
                    break;
                end
            end
            @(posedge aclk);
            #1;
        end
        drv_valid = 1'b0;
    endtask

    // send one payload frame into TX; optionally queue model expectations
    task automatic sendTxFrame(input logic [1:0] tid, input byte_q_t p, input bit use_model);
        if (use_model) begin
            tx_exp.push_back(8'h7D);
            pushEncoded({6'd0, tid});
            foreach (p[i]) pushEncoded(p[i]);
            tx_exp.push_back(8'h7E);
            foreach (p[i]) rx_exp.push_back({p[i], (i == p.size() - 1), 1'b0, tid});
        end
        foreach (p[i]) begin
            tx_frame_tvalid = 1'b1;
            tx_frame_tdata  = p[i];
            tx_frame_tlast  = (i == p.size() - 1);
            tx_frame_tid    = (i == 0) ? tid : 2'($urandom);
            for (int c = 0; ; c++) begin
                @(negedge aclk);
                if (tx_frame_tready) break;
                if (c > 500) begin
                    reportUnexpected("tx_frame_ready_timeout", {24'd0, p[i]});
                    break;
                end
            end
            @(posedge aclk);
            #1;
        end
        tx_frame_tvalid = 1'b0;
        tx_frame_tlast  = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        int c = 0;
        while ((rx_exp.size() + tx_exp.size() + s_exp.size()) != 0 && c < budget) begin
            @(posedge aclk);
            c++;
        end
        repeat (3) @(posedge aclk);
        #1;
        checkOutput("queues_drained", rx_exp.size() + tx_exp.size() + s_exp.size(), 0);
        rx_exp.delete();
        tx_exp.delete();
        s_exp.delete();
    endtask

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        byte_q_t q;
        logic [1:0] tid;
        tx_frame_tvalid = 1'b0;
        tx_frame_tdata  = 8'h00;
        tx_frame_tlast  = 1'b0;
        tx_frame_tid    = 2'd0;
        areset = 1'b1;
        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;

        // reset state
        @(negedge aclk);
        checkOutput("reset_rx_tvalid", rx_frame_tvalid, 0);
        checkOutput("reset_rx_tlast", rx_frame_tlast, 0);
        checkOutput("reset_rx_tuser", rx_frame_tuser, 0);
        checkOutput("reset_drop_cnt", rx_drop_cnt, 0);
        checkOutput("reset_tx_tvalid", tx_byte_tvalid, 0);
        checkOutput("reset_small_drop", s_drop_cnt, 0);
        @(posedge aclk);
        #1;

        // directed TX frame, expected wire bytes from a fixed table
        $display("[TB] directed TX frame");
        tx_rdy_drv = 1'b1;
        tx_exp = '{8'h7D, 8'h02, 8'h01, 8'h7F, 8'h7E, 8'h03, 8'h7E};
        q = '{8'h01, 8'h7E, 8'h03};
        sendTxFrame(2'd2, q, 1'b0);
        waitDrain(200);

        // directed RX frame with an escaped START inside the payload
        $display("[TB] directed RX frames");
        rx_exp = '{{8'hAA, 1'b0, 1'b0, 2'd1}, {8'h7D, 1'b0, 1'b0, 2'd1}, {8'hBB, 1'b1, 1'b0, 2'd1}};
        q = '{8'h7D, 8'h01, 8'hAA, 8'h7F, 8'h7D, 8'hBB, 8'h7E};
        applyStimulus(q);
        waitDrain(200);

        // aborted frame followed by a complete one
        rx_exp = '{{8'h11, 1'b0, 1'b0, 2'd0}, {8'h22, 1'b1, 1'b1, 2'd0}, {8'h33, 1'b1, 1'b0, 2'd3}};
        q = '{8'h7D, 8'h00, 8'h11, 8'h22, 8'h7D, 8'h03, 8'h33, 8'h7E};
        applyStimulus(q);
        waitDrain(200);
        checkOutput("drop_after_abort", rx_drop_cnt, 1);

        // oversize frame on the MAX_LEN=4 instance, then recovery
        $display("[TB] oversize frame");
        sel_small = 1'b1;
        s_exp = '{{8'h01, 1'b0, 1'b0, 2'd0}, {8'h02, 1'b0, 1'b0, 2'd0}, {8'h03, 1'b0, 1'b0, 2'd0},
                  {8'h04, 1'b1, 1'b1, 2'd0}, {8'h09, 1'b1, 1'b0, 2'd1}};
        q = '{8'h7D, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h7E, 8'h7D, 8'h01, 8'h09, 8'h7E};
        applyStimulus(q);
        waitDrain(200);
        checkOutput("small_drop_cnt", s_drop_cnt, 1);
        sel_small = 1'b0;

        // random frames looped TX -> RX with random backpressure
        $display("[TB] random loopback frames");
        loop_mode  = 1'b1;
        rand_ready = 1'b1;
        for (int f = 0; f < 200; f++) begin
            q.delete();
            for (int i = 0; i < int'($urandom_range(1, 12)); i++) begin
                if ($urandom_range(0, 3) == 0) q.push_back(8'h7D + 8'($urandom_range(0, 2)));
                else q.push_back(8'($urandom));
            end
            tid = 2'($urandom);
            sendTxFrame(tid, q, 1'b1);
        end
        waitDrain(20000);
        checkOutput("drop_after_loopback", rx_drop_cnt, 1);
        rand_ready = 1'b0;
        repeat (2) @(posedge aclk);
        #1;

        // reset in the middle of a frame on both paths
        $display("[TB] mid-frame reset");
        loop_mode  = 1'b0;
        tx_rdy_drv = 1'b0;
        q = '{8'h7D, 8'h01, 8'hAA};
        applyStimulus(q);
        tx_frame_tvalid = 1'b1;
        tx_frame_tdata  = 8'h55;
        tx_frame_tid    = 2'd1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        checkOutput("tx_busy_before_reset", tx_byte_tvalid, 1);
        @(posedge aclk);
        #1 areset = 1'b1;
        tx_frame_tvalid = 1'b0;
        @(posedge aclk);
        #1 areset = 1'b0;
        @(negedge aclk);
        checkOutput("post_reset_rx_tvalid", rx_frame_tvalid, 0);
        checkOutput("post_reset_tx_tvalid", tx_byte_tvalid, 0);
        checkOutput("post_reset_drop_cnt", rx_drop_cnt, 0);
        checkOutput("post_reset_small_tx_tvalid", s_tx_valid, 0);
        checkOutput("post_reset_small_tx_ready", s_tx_frame_ready, 0);
        @(posedge aclk);
        #1;
        // a STOP now must not release the discarded byte
        q = '{8'h7E};
        applyStimulus(q);
        loop_mode  = 1'b1;
        q = '{8'h7F, 8'h10, 8'h7D, 8'h20, 8'h7E};
        sendTxFrame(2'd3, q, 1'b1);
        waitDrain(500);
        checkOutput("drop_after_reset_frame", rx_drop_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
